// File: rtl/scan_bist_pkg.sv
// Shared types and helpers for the scan-BIST sequencer.
// State encoding, counter sizing, default signature width.
package scan_bist_pkg;

  localparam int SIG_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_bist_sequencer_if.sv
// Control/status bundle between BIST top and sequencer.
// master drives requests and signature, slave drives controls.
interface scan_bist_sequencer_if
  import scan_bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
);

  logic             bist_start;
  logic             bist_abort;
  logic [SIG_W-1:0] misr_sig;
  logic             test_mode;
  logic             scan_en;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             misr_clr;
  logic             misr_en;
  logic             busy;
  logic             bist_end;
  logic             pass_fail;

  modport master (
    output bist_start, bist_abort, misr_sig,
    input  test_mode, scan_en, lfsr_load, lfsr_en,
    input  misr_clr, misr_en, busy, bist_end, pass_fail
  );

  modport slave (
    input  bist_start, bist_abort, misr_sig,
    output test_mode, scan_en, lfsr_load, lfsr_en,
    output misr_clr, misr_en, busy, bist_end, pass_fail
  );

endinterface

// File: rtl/bist_seq_counter.sv
// Up-counter with clear and enable.
// tc flags count == limit so callers exit before any wrap.
module bist_seq_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/scan_bist_sequencer.sv
// Scan-BIST run sequencer: shift/capture patterns, unload,
// then a registered signature verdict.
module scan_bist_sequencer
  import scan_bist_pkg::*;
#(
  parameter int               CHAIN_LEN  = 12,
  parameter int               N_PATTERNS = 1000,
  parameter int               SIG_W      = SIG_W_DEF,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  scan_bist_sequencer_if.slave  bus
);

  localparam int SH_W = cnt_w(CHAIN_LEN);
  localparam int PT_W = cnt_w(N_PATTERNS);
  localparam logic [SH_W-1:0] SH_LIM = SH_W'(CHAIN_LEN - 1);
  localparam logic [PT_W-1:0] PT_LIM = PT_W'(N_PATTERNS - 1);

  state_t state, state_nx;
  logic   sh_tc, pt_tc;
  logic   running, abort_act;
  logic   sh_en, sh_clr, pt_en, pt_clr;
  logic   end_q, pf_q;
  logic   tm, se, ld, le, mc, me, bz;

  assign running   = state inside {INIT, SHIFT, CAPTURE,
                                   UNLOAD, COMPARE};
  assign abort_act = running && bus.bist_abort;

  // UNLOAD reuses the shift counter for its CHAIN_LEN cycles.
  assign sh_en  = state inside {SHIFT, UNLOAD};
  assign sh_clr = abort_act || !sh_en || sh_tc;
  assign pt_en  = (state == CAPTURE) && !pt_tc;
  assign pt_clr = abort_act ||
                  !(state inside {SHIFT, CAPTURE, UNLOAD});

  bist_seq_counter #(.W(SH_W)) u_shift_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (sh_clr),
    .en    (sh_en),
    .limit (SH_LIM),
    .tc    (sh_tc)
  );

  bist_seq_counter #(.W(PT_W)) u_pat_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (pt_clr),
    .en    (pt_en),
    .limit (PT_LIM),
    .tc    (pt_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      end_q <= 1'b0;
      pf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort_act) begin
        end_q <= 1'b0;
        pf_q  <= 1'b0;
      end else if (state == IDLE && bus.bist_start) begin
        end_q <= 1'b0;
        pf_q  <= 1'b0;
      end else if (state == COMPARE) begin
        end_q <= 1'b1;
        pf_q  <= (bus.misr_sig == GOLDEN_SIG);
      end
    end
  end

  always_comb begin
    state_nx = state;
    tm = 1'b0;
    se = 1'b0;
    ld = 1'b0;
    le = 1'b0;
    mc = 1'b0;
    me = 1'b0;
    bz = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.bist_start) state_nx = INIT;
      end
      INIT: begin
        tm = 1'b1;
        ld = 1'b1;
        mc = 1'b1;
        bz = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        tm = 1'b1;
        se = 1'b1;
        le = 1'b1;
        me = 1'b1;
        bz = 1'b1;
        if (sh_tc) state_nx = CAPTURE;
      end
      CAPTURE: begin
        tm = 1'b1;
        le = 1'b1;
        me = 1'b1;
        bz = 1'b1;
        state_nx = pt_tc ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        tm = 1'b1;
        se = 1'b1;
        le = 1'b1;
        me = 1'b1;
        bz = 1'b1;
        if (sh_tc) state_nx = COMPARE;
      end
      COMPARE: begin
        tm = 1'b1;
        bz = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (!bus.bist_start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_act) state_nx = IDLE;
  end

  assign bus.test_mode = tm;
  assign bus.scan_en   = se;
  assign bus.lfsr_load = ld;
  assign bus.lfsr_en   = le;
  assign bus.misr_clr  = mc;
  assign bus.misr_en   = me;
  assign bus.busy      = bz;
  assign bus.bist_end  = end_q;
  assign bus.pass_fail = pf_q;

endmodule

// File: tb/tb_scan_bist_sequencer.sv
// Bench for scan_bist_sequencer: run-timeline model plus
// directed scenarios with literal expectations.
module tb_scan_bist_sequencer;

  localparam int CL = 4;
  localparam int NP = 3;
  localparam logic [7:0] GOLD = 8'h5A;
  localparam int RUN_LEN = 2 + NP * (CL + 1) + CL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_bist_sequencer_if #(.SIG_W(8)) bus ();

  scan_bist_sequencer #(
    .CHAIN_LEN  (CL),
    .N_PATTERNS (NP),
    .SIG_W      (8),
    .GOLDEN_SIG (GOLD)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 running (m_k = cycle in run), 2 done
  int   m_phase = 0;
  int   m_k = 0;
  logic m_end = 1'b0;
  logic m_pf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_k = 0;
      m_end = 1'b0;
      m_pf = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.bist_start) begin
          m_phase = 1;
          m_k = 0;
          m_end = 1'b0;
          m_pf = 1'b0;
        end
        1: if (bus.bist_abort) begin
          m_phase = 0;
          m_end = 1'b0;
          m_pf = 1'b0;
        end else if (m_k == RUN_LEN - 1) begin
          m_phase = 2;
          m_end = 1'b1;
          m_pf = (bus.misr_sig == GOLD);
        end else begin
          m_k++;
        end
        default: if (!bus.bist_start) m_phase = 0;
      endcase
    end
  end

  // {test_mode,scan_en,lfsr_load,lfsr_en,misr_clr,misr_en,
  //  busy,bist_end,pass_fail}
  function automatic logic [8:0] exp_outs();
    logic tm, se, ld, le, mc, me, bz;
    int j;
    {tm, se, ld, le, mc, me, bz} = '0;
    if (m_phase == 1) begin
      tm = 1'b1;
      bz = 1'b1;
      if (m_k == 0) begin
        ld = 1'b1;
        mc = 1'b1;
      end else begin
        j = m_k - 1;
        if (j < NP * (CL + 1)) begin
          se = (j % (CL + 1)) < CL;
          le = 1'b1;
          me = 1'b1;
        end else if (j < NP * (CL + 1) + CL) begin
          se = 1'b1;
          le = 1'b1;
          me = 1'b1;
        end
      end
    end
    return {tm, se, ld, le, mc, me, bz, m_end, m_pf};
  endfunction

  function automatic logic [8:0] act_outs();
    return {bus.test_mode, bus.scan_en, bus.lfsr_load,
            bus.lfsr_en, bus.misr_clr, bus.misr_en,
            bus.busy, bus.bist_end, bus.pass_fail};
  endfunction

  int          busy_cnt = 0;
  int          load_cnt = 0;
  int          clr_cnt = 0;
  logic [31:0] scan_hist = '0;

  always @(negedge clk) begin
    chk("outs", 32'(act_outs()), 32'(exp_outs()));
    if (bus.busy) begin
      busy_cnt++;
      scan_hist = {scan_hist[30:0], bus.scan_en};
    end
    if (bus.lfsr_load) load_cnt++;
    if (bus.misr_clr) clr_cnt++;
  end

  int b0, l0, c0;
  logic [20:0] sh_exp;

  initial begin
    sh_exp = 21'b0_1111_0_1111_0_1111_0_1111_0;
    bus.bist_start = 1'b0;
    bus.bist_abort = 1'b0;
    bus.misr_sig = 8'h5A;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset asserted mid-run clears everything at once
    @(negedge clk);
    bus.bist_start = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_outs", 32'(act_outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.bist_start = 1'b0;
    b0 = busy_cnt;
    repeat (10) @(negedge clk);
    chk("idle_quiet", busy_cnt - b0, 0);

    // passing run
    b0 = busy_cnt;
    l0 = load_cnt;
    c0 = clr_cnt;
    bus.misr_sig = 8'h5A;
    bus.bist_start = 1'b1;
    repeat (RUN_LEN + 3) @(negedge clk);
    chk("pass_busy_len", busy_cnt - b0, 21);
    chk("pass_scan_pat", 32'(scan_hist[20:0]), 32'(sh_exp));
    chk("pass_end", bus.bist_end, 1);
    chk("pass_pf", bus.pass_fail, 1);
    chk("pass_load_pulses", load_cnt - l0, 1);
    chk("pass_clr_pulses", clr_cnt - c0, 1);

    // start held: no rerun; then drop and reassert
    b0 = busy_cnt;
    repeat (8) @(negedge clk);
    chk("hold_no_rerun", busy_cnt - b0, 0);
    chk("hold_end", bus.bist_end, 1);
    bus.bist_start = 1'b0;
    @(negedge clk);
    chk("idle_keeps_end", bus.bist_end, 1);
    bus.bist_start = 1'b1;
    bus.misr_sig = 8'h5B;
    b0 = busy_cnt;
    @(negedge clk);
    chk("restart_end_clr", bus.bist_end, 0);
    chk("restart_busy", bus.busy, 1);
    repeat (RUN_LEN + 2) @(negedge clk);
    chk("fail_busy_len", busy_cnt - b0, 21);
    chk("fail_end", bus.bist_end, 1);
    chk("fail_pf", bus.pass_fail, 0);

    // abort in second capture
    bus.bist_start = 1'b0;
    repeat (2) @(negedge clk);
    bus.misr_sig = 8'h5A;
    bus.bist_start = 1'b1;
    repeat (11) @(negedge clk);
    chk("cap2_scan_en", bus.scan_en, 0);
    chk("cap2_busy", bus.busy, 1);
    bus.bist_abort = 1'b1;
    bus.bist_start = 1'b0;
    @(negedge clk);
    bus.bist_abort = 1'b0;
    chk("abort_outs", 32'(act_outs()), 32'd0);
    repeat (3) @(negedge clk);

    // start and abort together in idle: start wins
    b0 = busy_cnt;
    l0 = load_cnt;
    bus.bist_start = 1'b1;
    bus.bist_abort = 1'b1;
    @(negedge clk);
    bus.bist_abort = 1'b0;
    chk("start_beats_abort", bus.busy, 1);
    repeat (RUN_LEN + 2) @(negedge clk);
    chk("rerun_busy_len", busy_cnt - b0, 21);
    chk("rerun_end", bus.bist_end, 1);
    chk("rerun_pf", bus.pass_fail, 1);
    chk("rerun_load_pulses", load_cnt - l0, 1);
    bus.bist_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
